// File: rtl/io_seq_pkg.sv
// io_seq_pkg: shared FSM encoding and default sizing for io_seq_monitor
package io_seq_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;
    localparam int DEF_TMO_W = 24;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } state_e;
endpackage

// File: rtl/io_sync2.sv
// io_sync2: two-flop synchroniser for asynchronous input pins
module io_sync2 #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] s1_q, s2_q;
    // Two-stage capture; only the second stage is safe to consume
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end
    assign q_o = s2_q;
endmodule

// File: rtl/io_seq_monitor.sv
// io_seq_monitor: checks that synchronised pins walk through a loaded pattern table
// Define IO_SEQ_MONITOR_STRICT_EN to fail on any value that is neither the current nor the previous entry.
module io_seq_monitor import io_seq_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int TMO_W = DEF_TMO_W
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [WIDTH-1:0]         load_data,
    input  logic [$clog2(DEPTH):0]   seq_len,
    input  logic [TMO_W-1:0]         tmo_cycles,
    input  logic                     start,
    input  logic [WIDTH-1:0]         port_in,
    output logic                     busy,
    output logic                     pass,
    output logic                     fail,
    output logic                     tmo_flag,
    output logic [$clog2(DEPTH):0]   step_idx
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    logic [WIDTH-1:0] port_s;
    logic [WIDTH-1:0] tbl_q [DEPTH];
    state_e           state_q, state_d;
    logic [LW-1:0]    step_q, step_d, len_q, len_d;
    logic [TMO_W-1:0] lim_q, lim_d, cnt_q, cnt_d, cnt_inc;
    logic             pass_q, pass_d, fail_q, fail_d, tmo_q, tmo_d;
    logic             match, expire, glitch;

    io_sync2 #(.WIDTH(WIDTH)) u_sync (
        .CLK (CLK),
        .RST (RST),
        .d_i (port_in),
        .q_o (port_s)
    );

    // Pattern table write port; contents deliberately survive reset
    always_ff @(posedge CLK) begin
        if (load_en && state_q != RUN && {1'b0, load_addr} < DEPTH_L)
            tbl_q[load_addr] <= load_data;
    end

    assign match   = port_s == tbl_q[step_q[AW-1:0]];
    assign cnt_inc = cnt_q + TMO_W'(1);
    assign expire  = lim_q != '0 && cnt_inc == lim_q;

`ifdef IO_SEQ_MONITOR_STRICT_EN
    logic [AW-1:0] prev_idx;
    assign prev_idx = step_q[AW-1:0] - AW'(1);
    assign glitch   = step_q != '0 && port_s != tbl_q[prev_idx];
`else
    assign glitch = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            step_q  <= '0;
            len_q   <= '0;
            lim_q   <= '0;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            len_q   <= len_d;
            lim_q   <= lim_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next state: a match beats both glitch and timeout; start only arms outside RUN
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        len_d   = len_q;
        lim_d   = lim_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        tmo_d   = tmo_q;
        if (state_q == RUN) begin
            if (match) begin
                step_d = step_q + LW'(1);
                cnt_d  = '0;
                if (step_d == len_q) begin
                    state_d = PASS;
                    pass_d  = 1'b1;
                end
            end else if (glitch) begin
                state_d = FAIL;
                fail_d  = 1'b1;
            end else begin
                cnt_d = cnt_inc;
                if (expire) begin
                    state_d = FAIL;
                    fail_d  = 1'b1;
                    tmo_d   = 1'b1;
                end
            end
        end else if (start) begin
            len_d   = seq_len > DEPTH_L ? DEPTH_L : seq_len;
            lim_d   = tmo_cycles;
            step_d  = '0;
            cnt_d   = '0;
            pass_d  = seq_len == '0;
            fail_d  = 1'b0;
            tmo_d   = 1'b0;
            state_d = seq_len == '0 ? PASS : RUN;
        end
    end

    // Outputs
    always_comb begin
        busy     = state_q == RUN;
        pass     = pass_q;
        fail     = fail_q;
        tmo_flag = tmo_q;
        step_idx = step_q;
    end
endmodule
